// File: rtl/n2_imem_resp_if.sv
// rtl/n2_imem_resp_if.sv - fetch request/response and SRAM signals of the instruction memory port
interface n2_imem_resp_if #(
  parameter int ADDR_W = 12
) ();
  logic              flush_i;
  logic              instr_req_i;
  logic [1:0]        instr_req_2b_i;
  logic [31:0]       instr_addr_i;
  logic              instr_gnt_o;
  logic              sram_en_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [63:0]       sram_rdata_i;
  logic              instr_valid_o;
  logic [1:0]        instr_valid_2b_o;
  logic [63:0]       instr_data_o;
  logic [31:0]       instr_pc_o;
  logic              instr_err_o;

  modport slave (
    input  flush_i, instr_req_i, instr_req_2b_i, instr_addr_i, sram_rdata_i,
    output instr_gnt_o, sram_en_o, sram_addr_o,
    output instr_valid_o, instr_valid_2b_o, instr_data_o, instr_pc_o, instr_err_o
  );

  modport master (
    output flush_i, instr_req_i, instr_req_2b_i, instr_addr_i, sram_rdata_i,
    input  instr_gnt_o, sram_en_o, sram_addr_o,
    input  instr_valid_o, instr_valid_2b_o, instr_data_o, instr_pc_o, instr_err_o
  );
endinterface

// File: rtl/n2_imem_resp.sv
// rtl/n2_imem_resp.sv - instruction SRAM fetch responder with optional wait cycles and flush
module n2_imem_resp #(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_DWORDS  = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic clk,
  input  logic resetn,
  n2_imem_resp_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} state_t;

  localparam logic [28:0] MEM_LIMIT = 29'(MEM_DWORDS);
  localparam logic [1:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        done;
  logic        oor;
  logic [31:2] addr_q;
  logic [1:0]  mask_q;
  logic        oor_q;
  logic [63:0] rdata_q;
  logic [63:0] rd_word;

  // Grant, SRAM strobe and next-state decode; flush dominates and returns to idle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = ((state == S_READ) && (WAIT_CYCLES == 0)) ||
              ((state == S_WAIT) && (cnt == 2'd0));
    oor     = (bus.instr_addr_i[31:3] >= MEM_LIMIT);
    bus.instr_gnt_o = resetn && bus.instr_req_i && !bus.flush_i &&
                      ((state == S_IDLE) || done);
    bus.sram_en_o   = bus.instr_gnt_o && !oor;
    bus.sram_addr_o = bus.instr_addr_i[ADDR_W+2:3];
    rd_word = (state == S_READ) ? bus.sram_rdata_i : rdata_q;
    if (bus.flush_i) begin
      state_n = S_IDLE;
      cnt_n   = 2'd0;
    end else begin
      case (state)
        S_IDLE: if (bus.instr_gnt_o) state_n = S_READ;
        S_READ: begin
          if (WAIT_CYCLES == 0) begin
            state_n = bus.instr_gnt_o ? S_READ : S_IDLE;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt == 2'd0) state_n = bus.instr_gnt_o ? S_READ : S_IDLE;
          else             cnt_n   = cnt - 2'd1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // FSM state and wait down-counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the granted request and the SRAM word returned in the read cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      mask_q  <= 2'b00;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (bus.instr_gnt_o) begin
        addr_q <= bus.instr_addr_i[31:2];
        mask_q <= bus.instr_req_2b_i;
        oor_q  <= oor;
      end
      if (state == S_READ) rdata_q <= bus.sram_rdata_i;
    end
  end

  // Register the one-cycle response at completion unless a flush cancels it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.instr_valid_o    <= 1'b0;
      bus.instr_valid_2b_o <= 2'b00;
      bus.instr_err_o      <= 1'b0;
      bus.instr_data_o     <= '0;
      bus.instr_pc_o       <= '0;
    end else if (done && !bus.flush_i) begin
      bus.instr_valid_o <= 1'b1;
      bus.instr_pc_o    <= {addr_q, 2'b00};
      if (oor_q) begin
        bus.instr_err_o      <= 1'b1;
        bus.instr_data_o     <= '0;
        bus.instr_valid_2b_o <= 2'b01;
      end else if (addr_q[2]) begin
        bus.instr_err_o      <= 1'b0;
        bus.instr_data_o     <= {32'h0, rd_word[63:32]};
        bus.instr_valid_2b_o <= (mask_q == 2'b00) ? 2'b00 : 2'b01;
      end else begin
        bus.instr_err_o      <= 1'b0;
        bus.instr_data_o     <= rd_word;
        bus.instr_valid_2b_o <= mask_q;
      end
    end else begin
      bus.instr_valid_o    <= 1'b0;
      bus.instr_valid_2b_o <= 2'b00;
      bus.instr_err_o      <= 1'b0;
    end
  end

endmodule
